// File: rtl/buffer_ctrl.sv
// Sequencer for the shared sliding-window buffer: picks one sample channel,
// paces its words with an idle gap, and flushes/re-warms on channel switch.
// Optional sticky overflow flag: define BUFFER_CTRL_OVERFLOW_EN.
module buffer_ctrl #(
  parameter int CHANNELS = 4,
  parameter int GAP      = 2,
  parameter int WARMUP   = 48
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [16*CHANNELS-1:0]  sampleIn,
  input  logic [CHANNELS-1:0]     sampleValid,
  input  logic [3:0]              chanSel,
  input  logic                    selStrobe,
  input  logic                    enable,
  output logic                    bufReset,
  output logic signed [15:0]      stream,
  output logic                    wordValid,
  output logic [3:0]              activeChan,
  output logic                    ready,
  output logic                    overflow
);

  localparam logic [4:0] NCH    = 5'(CHANNELS);
  localparam logic [3:0] GAP_L  = 4'(GAP);
  localparam logic [7:0] WARM_L = 8'(WARMUP);

  typedef enum logic [1:0] {FLUSH, FILL, RUN} state_t;

  state_t             state;
  logic signed [15:0] hold;
  logic               pending;
  logic [7:0]         warm;
  logic [3:0]         gap;

  // Widen to 16 channels so a 4-bit channel index always selects in range.
  logic [15:0]        valid_ext;
  logic [255:0]       samp_ext;
  logic signed [15:0] sample;
  logic               sel_ok, live, capture, issue;

  assign valid_ext = 16'(sampleValid);
  assign samp_ext  = 256'(sampleIn);
  assign sample    = samp_ext[{activeChan, 4'b0000} +: 16];

  // A valid switch request wins over any capture or issue in the same cycle.
  assign sel_ok  = selStrobe && ({1'b0, chanSel} < NCH);
  assign live    = (state != FLUSH);
  assign capture = live && !sel_ok && valid_ext[activeChan];
  assign issue   = live && !sel_ok && pending && enable && (gap == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= FLUSH;
      bufReset   <= 1'b1;
      stream     <= '0;
      wordValid  <= 1'b0;
      activeChan <= '0;
      ready      <= 1'b0;
      overflow   <= 1'b0;
      hold       <= '0;
      pending    <= 1'b0;
      warm       <= '0;
      gap        <= '0;
    end else begin
      wordValid <= 1'b0;
      if (gap != 4'd0) gap <= gap - 4'd1;

      if (sel_ok) begin
        state      <= FLUSH;
        bufReset   <= 1'b1;
        ready      <= 1'b0;
        activeChan <= chanSel;
        pending    <= 1'b0;
      end else begin
        case (state)
          FLUSH: begin
            bufReset <= 1'b0;
            warm     <= '0;
            pending  <= 1'b0;
            ready    <= 1'b0;
`ifdef BUFFER_CTRL_OVERFLOW_EN
            overflow <= 1'b0;
`endif
            state    <= FILL;
          end
          default: begin
            // Registered count is checked, so ready lands one cycle after the last warm-up word.
            if (state == FILL && warm >= WARM_L) begin
              state <= RUN;
              ready <= 1'b1;
            end
            if (issue) begin
              stream    <= hold;
              wordValid <= 1'b1;
              gap       <= GAP_L;
              if (warm != 8'hFF) warm <= warm + 8'd1;
            end
            // On capture+issue the old hold goes out and the new sample stays pending.
            if (capture) begin
              hold    <= sample;
              pending <= 1'b1;
`ifdef BUFFER_CTRL_OVERFLOW_EN
              if (pending && !issue) overflow <= 1'b1;
`endif
            end else if (issue) begin
              pending <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_ctrl.sv
// Self-checking bench for buffer_ctrl: directed scenarios plus randomized
// traffic compared cycle-by-cycle against a behavioural model.
module tb_buffer_ctrl;

  localparam int CH = 4;
  localparam int GP = 2;
  localparam int WU = 48;
`ifdef BUFFER_CTRL_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [23:0] RSTV = {1'b1, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0};

  logic               clock = 1'b0;
  logic               rst_n = 1'b1;
  logic [16*CH-1:0]   sampleIn = '0;
  logic [CH-1:0]      sampleValid = '0;
  logic [3:0]         chanSel = '0;
  logic               selStrobe = 1'b0;
  logic               enable = 1'b0;
  logic               bufReset, wordValid, ready, overflow;
  logic signed [15:0] stream;
  logic [3:0]         activeChan;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  buffer_ctrl #(.CHANNELS(CH), .GAP(GP), .WARMUP(WU)) dut (
    .clock(clock), .reset(rst_n), .sampleIn(sampleIn), .sampleValid(sampleValid),
    .chanSel(chanSel), .selStrobe(selStrobe), .enable(enable),
    .bufReset(bufReset), .stream(stream), .wordValid(wordValid),
    .activeChan(activeChan), .ready(ready), .overflow(overflow)
  );

  // Behavioural model: phase 0 flushing, 1 warming up, 2 running.
  logic        m_br, m_wv, m_rdy, m_ovf, m_pend;
  logic [15:0] m_stream, m_hold;
  logic [3:0]  m_chan;
  logic [15:0] sv_ext;
  int          phase, words, cool;
  bit          sw, live, cap, iss;

  assign sv_ext = 16'(sampleValid);

  initial forever begin
    @(posedge clock or negedge rst_n);
    if (!rst_n) begin
      m_br = 1'b1; m_stream = '0; m_wv = 1'b0; m_chan = '0; m_rdy = 1'b0;
      m_ovf = 1'b0; m_pend = 1'b0; m_hold = '0; phase = 0; words = 0; cool = 0;
    end else begin
      sw   = selStrobe && (chanSel < 4'(CH));
      live = (phase != 0);
      cap  = live && !sw && sv_ext[m_chan];
      iss  = live && !sw && m_pend && enable && (cool == 0);
      m_wv = 1'b0;
      if (cool > 0) cool--;
      if (sw) begin
        phase = 0; m_br = 1'b1; m_rdy = 1'b0; m_chan = chanSel; m_pend = 1'b0;
      end else if (phase == 0) begin
        m_br = 1'b0; words = 0; m_pend = 1'b0; m_rdy = 1'b0; m_ovf = 1'b0; phase = 1;
      end else begin
        if (phase == 1 && words >= WU) begin phase = 2; m_rdy = 1'b1; end
        if (iss) begin m_stream = m_hold; m_wv = 1'b1; cool = GP; words++; end
        if (cap) begin
          if (m_pend && !iss && OVF_EN) m_ovf = 1'b1;
          m_hold = sampleIn[16*m_chan +: 16];
          m_pend = 1'b1;
        end else if (iss) m_pend = 1'b0;
      end
    end
  end

  wire [23:0] obs  = {bufReset, stream, wordValid, activeChan, ready, overflow};
  wire [23:0] expv = {m_br, m_stream, m_wv, m_chan, m_rdy, m_ovf};

  task automatic tick();
    @(posedge clock);
    #1;
    sampleValid = '0;
    selStrobe   = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick(); tick();
    total++; if (obs !== RSTV) $display("FAIL reset_values: got %h want %h", obs, RSTV); else passed++;
    rst_n = 1'b1;
    #1;
    total++; if (bufReset !== 1'b1) $display("FAIL reset_release_bufreset: got %b want 1", bufReset); else passed++;
    tick();
    total++; if (obs !== 24'h0) $display("FAIL flush_one_cycle: got %h want 000000", obs); else passed++;
    tick(); tick(); tick();
    total++; if (obs !== 24'h0) $display("FAIL fill_idle: got %h want 000000", obs); else passed++;
  endtask

  task automatic test_fill();
    int got = 0;
    bit chk_rdy = 1'b0;
    enable = 1'b1; chanSel = 4'd2; selStrobe = 1'b1;
    tick();
    total++;
    if ({bufReset, activeChan, ready} !== {1'b1, 4'd2, 1'b0})
      $display("FAIL fill_switch: got %b want 1_0010_0", {bufReset, activeChan, ready});
    else passed++;
    tick();
    total++; if (bufReset !== 1'b0) $display("FAIL fill_flush_len: got %b want 0", bufReset); else passed++;
    for (int k = 1; k <= WU; k++) begin
      for (int j = 0; j < 4; j++) begin
        sampleIn = {$urandom, $urandom};
        if (j == 0) begin
          sampleIn[47:32] = 16'(k);
          sampleValid = 4'($urandom) | 4'b0100;
        end else sampleValid = 4'($urandom) & 4'b1011;
        tick();
        if (chk_rdy) begin
          chk_rdy = 1'b0;
          total++; if (ready !== 1'b1) $display("FAIL ready_rise: got %b want 1", ready); else passed++;
        end
        if (wordValid === 1'b1) begin
          got++;
          total++;
          if (stream !== 16'(got)) $display("FAIL fill_word: got %h want %h", stream, 16'(got)); else passed++;
          if (got == WU) begin
            chk_rdy = 1'b1;
            total++; if (ready !== 1'b0) $display("FAIL ready_early: got %b want 0", ready); else passed++;
          end
        end
      end
    end
    total++; if (got != WU) $display("FAIL fill_count: got %0d want %0d", got, WU); else passed++;
  endtask

  task automatic test_burst();
    logic [15:0] q[$];
    logic [15:0] exp_w[5] = '{16'h0100, 16'h0103, 16'h0106, 16'h0109, 16'h010B};
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin
        sampleIn = {$urandom, $urandom};
        sampleIn[47:32] = 16'h0100 + 16'(i);
        sampleValid = 4'b0100;
      end
      tick();
      if (wordValid === 1'b1) q.push_back(stream);
    end
    total++; if (q.size() != 5) $display("FAIL burst_count: got %0d want 5", q.size()); else passed++;
    for (int i = 0; i < 5 && i < q.size(); i++) begin
      total++; if (q[i] !== exp_w[i]) $display("FAIL burst_word%0d: got %h want %h", i, q[i], exp_w[i]); else passed++;
    end
    total++; if (overflow !== OVF_EN) $display("FAIL burst_overflow: got %b want %b", overflow, OVF_EN); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL burst_ready: got %b want 1", ready); else passed++;
  endtask

  task automatic test_switch_drop();
    int wv = 0;
    sampleIn = {$urandom, $urandom};
    sampleIn[31:16] = 16'h7777;
    sampleValid = 4'b0010; chanSel = 4'd1; selStrobe = 1'b1;
    tick();
    total++;
    if ({bufReset, ready, activeChan, wordValid} !== {1'b1, 1'b0, 4'd1, 1'b0})
      $display("FAIL switch_flush: got %b want 1_0_0001_0", {bufReset, ready, activeChan, wordValid});
    else passed++;
    tick();
    total++; if (bufReset !== 1'b0) $display("FAIL switch_flush_len: got %b want 0", bufReset); else passed++;
    for (int i = 0; i < 5; i++) begin tick(); if (wordValid === 1'b1) wv++; end
    total++; if (wv != 0) $display("FAIL switch_drop: got %0d words want 0", wv); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL switch_ovf_clear: got %b want 0", overflow); else passed++;
  endtask

  task automatic test_bad_sel();
    for (int k = 0; k < WU; k++) begin
      sampleIn = {$urandom, $urandom};
      sampleValid = 4'b0010;
      tick(); tick(); tick();
    end
    tick();
    total++; if (ready !== 1'b1) $display("FAIL chan1_ready: got %b want 1", ready); else passed++;
    chanSel = 4'd7; selStrobe = 1'b1;
    tick();
    total++;
    if ({bufReset, activeChan, ready} !== {1'b0, 4'd1, 1'b1})
      $display("FAIL bad_sel7: got %b want 0_0001_1", {bufReset, activeChan, ready});
    else passed++;
    chanSel = 4'd4; selStrobe = 1'b1;
    tick();
    total++;
    if ({bufReset, activeChan, ready} !== {1'b0, 4'd1, 1'b1})
      $display("FAIL bad_sel4: got %b want 0_0001_1", {bufReset, activeChan, ready});
    else passed++;
  endtask

  task automatic test_enable_hold();
    int wv = 0;
    enable = 1'b0;
    sampleIn = {$urandom, $urandom};
    sampleIn[31:16] = 16'h1234;
    sampleValid = 4'b0010;
    tick();
    if (wordValid === 1'b1) wv++;
    for (int i = 0; i < 9; i++) begin tick(); if (wordValid === 1'b1) wv++; end
    total++; if (wv != 0) $display("FAIL enable_hold: got %0d words want 0", wv); else passed++;
    enable = 1'b1;
    tick();
    total++;
    if ({wordValid, stream} !== {1'b1, 16'h1234})
      $display("FAIL enable_release: got %b/%h want 1/1234", wordValid, stream);
    else passed++;
    wv = 0;
    for (int i = 0; i < 4; i++) begin tick(); if (wordValid === 1'b1) wv++; end
    total++; if (wv != 0) $display("FAIL enable_single: got %0d extra words want 0", wv); else passed++;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      sampleIn = {$urandom, $urandom};
      for (int c = 0; c < CH; c++) sampleValid[c] = ($urandom % 3 == 0);
      enable = ($urandom % 4 != 0);
      if ($urandom % 400 == 0) begin
        selStrobe = 1'b1;
        chanSel = 4'($urandom % 16);
      end
      tick();
      total++; if (obs !== expv) $display("FAIL random_cycle%0d: got %h want %h", i, obs, expv); else passed++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    total++; if (obs !== RSTV) $display("FAIL async_reset: got %h want %h", obs, RSTV); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (obs !== 24'h0) $display("FAIL async_release: got %h want 000000", obs); else passed++;
    test_random(300);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_burst();
    test_switch_drop();
    test_bad_sel();
    test_enable_hold();
    test_random(3000);
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
